// File: rtl/mem_pkg.sv
// Shared types for the data memory unit: access sizes, controller states
// and the byte-lane mask helper used by stores.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic logic [3:0] lane_mask(input size_e sz, input logic [1:0] off);
        case (sz)
            SZ_BYTE: return 4'b0001 << off;
            SZ_HALF: return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_unit_if.sv
// Request/response bus plus debug probe port of the data memory unit.
interface data_mem_unit_if #(
    parameter int ADDR_W  = 32,
    parameter int PROBE_W = 9
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [PROBE_W-1:0] probe_addr;
    logic [31:0]       probe_data;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output rsp_ready, probe_addr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, probe_data
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  rsp_ready, probe_addr,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, probe_data
    );
endinterface

// File: rtl/data_mem_unit_load_align.sv
// Picks the addressed byte/half out of a stored word and extends it to 32 bits.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  size_e       size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  off_i,
    output logic [31:0] data_o
);
    logic [31:0] shifted;

    always_comb begin
        shifted = word_i >> {off_i, 3'b000};
        data_o  = word_i;
        case (size_i)
            SZ_BYTE: data_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
            SZ_HALF: data_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
            default: data_o = word_i;
        endcase
    end
endmodule

// File: rtl/data_mem_unit.sv
// Single-port word memory with byte/half/word loads and stores, a fixed
// read latency and a one-outstanding-request valid/ready handshake.
module data_mem_unit
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 512,
    parameter int RD_LATENCY  = 1,
    parameter int ADDR_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    data_mem_unit_if.slave   bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W-1:0] DEPTH_BYTES = ADDR_W'(DEPTH_WORDS * 4);
    localparam logic [1:0] CNT_INIT = 2'(RD_LATENCY - 1);

    logic [31:0] mem [DEPTH_WORDS];

    state_e           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    size_e            size_q, size_d;
    logic             uns_q, uns_d;
    logic [1:0]       off_q, off_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    size_e            req_sz;
    logic [IDX_W-1:0] req_idx;
    logic             req_err;
    logic             do_store;
    logic [3:0]       store_mask;
    logic [31:0]      store_data;
    logic [31:0]      load_data;

    always_comb begin
        req_sz  = size_e'(bus.req_size);
        req_idx = bus.req_addr[2 +: IDX_W];
        req_err = (req_sz == SZ_ILL)
               || (req_sz == SZ_HALF && bus.req_addr[0])
               || (req_sz == SZ_WORD && bus.req_addr[1:0] != 2'b00)
               || (bus.req_addr >= DEPTH_BYTES);
    end

    // Writes happen on the acceptance edge itself, never under reset.
    assign do_store   = rst_n && bus.req_valid && (state_q == IDLE) && bus.req_we && !req_err;
    assign store_mask = lane_mask(req_sz, bus.req_addr[1:0]);

    always_comb begin
        case (req_sz)
            SZ_BYTE: store_data = {4{bus.req_wdata[7:0]}};
            SZ_HALF: store_data = {2{bus.req_wdata[15:0]}};
            default: store_data = bus.req_wdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_store) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (store_mask[b]) mem[req_idx][8*b +: 8] <= store_data[8*b +: 8];
            end
        end
    end

    load_align u_load_align (
        .word_i     (mem[idx_q]),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .off_i      (off_q),
        .data_o     (load_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        size_d  = size_q;
        uns_d   = uns_q;
        off_d   = off_q;
        idx_d   = idx_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    size_d  = req_sz;
                    uns_d   = bus.req_unsigned;
                    off_d   = bus.req_addr[1:0];
                    idx_d   = req_idx;
                    rdata_d = '0;
                    err_d   = req_err;
                    if (req_err || bus.req_we) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d = RESP;
                    rdata_d = load_data;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            off_q   <= '0;
            idx_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            off_q   <= off_d;
            idx_q   <= idx_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_rdata  = rdata_q;
    assign bus.rsp_err    = err_q;
    assign bus.probe_data = mem[bus.probe_addr];
endmodule

// File: tb/tb_data_mem_unit.sv
// Randomized bench for data_mem_unit against a byte-addressed reference memory.
module tb_data_mem_unit;
    localparam int DEPTH = 64;
    localparam int LAT   = 3;
    localparam int AW    = 32;
    localparam int PW    = $clog2(DEPTH);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_mem_unit_if #(.ADDR_W(AW), .PROBE_W(PW)) bus ();

    data_mem_unit #(.DEPTH_WORDS(DEPTH), .RD_LATENCY(LAT), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [7:0] ref_mem [DEPTH*4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic logic ref_err(input logic [1:0] sz, input logic [31:0] addr);
        if (sz == 2'b11) return 1'b1;
        if (sz == 2'b01 && addr % 2 != 0) return 1'b1;
        if (sz == 2'b10 && addr % 4 != 0) return 1'b1;
        return addr >= 32'(DEPTH * 4);
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns, input logic [31:0] addr);
        int n = 1 << sz;
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) v = v | ({24'b0, ref_mem[int'(addr) + i]} << (8 * i));
        if (n < 4 && !uns && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    function automatic logic [31:0] ref_word(input int idx);
        return {ref_mem[4*idx+3], ref_mem[4*idx+2], ref_mem[4*idx+1], ref_mem[4*idx]};
    endfunction

    task automatic probe_chk(input string tag, input int idx, input logic [31:0] exp);
        bus.probe_addr = PW'(idx);
        #1;
        check(tag, bus.probe_data, exp);
    endtask

    // Issues one request, measures edges from acceptance to rsp_valid,
    // stalls the response for `hold` cycles, then consumes it.
    task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input int hold,
                        output logic [31:0] rd, output logic er, output int lat, output logic ok);
        int guard = 0;
        ok = 1'b0; rd = '0; er = 1'b0; lat = 0;
        @(negedge clk);
        bus.req_we = we; bus.req_size = sz; bus.req_unsigned = uns;
        bus.req_addr = addr; bus.req_wdata = wd; bus.req_valid = 1'b1;
        while (bus.req_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            check("accept_timeout", 32'd0, 32'd1);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        while (bus.rsp_valid !== 1'b1 && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (lat >= 50) begin
            check("rsp_timeout", 32'd0, 32'd1);
            return;
        end
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check("hold_valid", 32'(bus.rsp_valid), 32'd1);
            check("hold_rdata", bus.rsp_rdata, rd);
            check("hold_err", 32'(bus.rsp_err), 32'(er));
            check("hold_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        check("consume_valid", 32'(bus.rsp_valid), 32'd0);
        check("consume_req_ready", 32'(bus.req_ready), 32'd1);
        ok = 1'b1;
    endtask

    task automatic op(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd, input int hold,
                      output logic [31:0] rd, output logic er);
        logic        exp_err = ref_err(sz, addr);
        logic [31:0] exp_rd  = (exp_err || we) ? 32'd0 : ref_load(sz, uns, addr);
        int          exp_lat = (exp_err || we) ? 0 : LAT;
        int          lat;
        logic        ok;
        int          pidx;
        xact(we, sz, uns, addr, wd, hold, rd, er, lat, ok);
        if (!ok) return;
        check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_err"}, 32'(er), 32'(exp_err));
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        if (!exp_err && we) begin
            for (int i = 0; i < (1 << sz); i++) ref_mem[int'(addr) + i] = wd[8*i +: 8];
        end
        pidx = (addr < 32'(DEPTH * 4)) ? int'(addr >> 2) : int'($urandom_range(0, DEPTH - 1));
        probe_chk({tag, "_probe"}, pidx, ref_word(pidx));
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [1:0]  sz;
        logic [31:0] addr;

        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.rsp_ready = 1'b0; bus.probe_addr = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int w = 0; w < DEPTH; w++) op("fill", 1'b1, 2'b10, 1'b0, 32'(w * 4), $urandom, 0, rd, er);

        op("st_word40", 1'b1, 2'b10, 1'b0, 32'h40, 32'hDEAD_BEEF, 0, rd, er);
        op("ld_word40", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1, rd, er);
        check("ld_word40_const", rd, 32'hDEAD_BEEF);
        op("st_byte41", 1'b1, 2'b00, 1'b0, 32'h41, 32'h1234_5680, 0, rd, er);
        op("ld_byte41_s", 1'b0, 2'b00, 1'b0, 32'h41, 32'h0, 0, rd, er);
        check("ld_byte41_s_const", rd, 32'hFFFF_FF80);
        op("ld_byte41_u", 1'b0, 2'b00, 1'b1, 32'h41, 32'h0, 0, rd, er);
        check("ld_byte41_u_const", rd, 32'h0000_0080);
        op("ld_word40b", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 0, rd, er);
        check("ld_word40b_const", rd, 32'hDEAD_80EF);
        op("ld_half43", 1'b0, 2'b01, 1'b0, 32'h43, 32'h0, 0, rd, er);
        check("ld_half43_err_const", 32'(er), 32'd1);
        op("st_word42", 1'b1, 2'b10, 1'b0, 32'h42, 32'h1111_1111, 0, rd, er);
        check("st_word42_err_const", 32'(er), 32'd1);
        probe_chk("st_word42_probe_const", 32'h10, 32'hDEAD_80EF);
        op("ld_oor", 1'b0, 2'b10, 1'b0, 32'(DEPTH * 4), 32'h0, 0, rd, er);
        check("ld_oor_err_const", 32'(er), 32'd1);
        op("ld_sz11", 1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 0, rd, er);
        check("ld_sz11_err_const", 32'(er), 32'd1);
        op("stall5", 1'b0, 2'b01, 1'b0, 32'h42, 32'h0, 5, rd, er);

        repeat (200) begin
            sz   = 2'($urandom_range(0, 3));
            addr = 32'($urandom_range(0, DEPTH * 4 + 7));
            if ($urandom_range(0, 15) == 0) addr = $urandom;
            op("rand", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr,
               $urandom, int'($urandom_range(0, 2)), rd, er);
        end

        // Reset while a load is waiting, with a store presented during reset.
        @(negedge clk);
        bus.req_we = 1'b0; bus.req_size = 2'b10; bus.req_unsigned = 1'b0;
        bus.req_addr = 32'h40; bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        check("wait_req_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        bus.req_we = 1'b1; bus.req_addr = 32'h40; bus.req_wdata = 32'hCAFE_F00D; bus.req_valid = 1'b1;
        @(posedge clk);
        #1 check("rstwait_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            check("post_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        probe_chk("rst_store_dropped", 32'h10, ref_word(32'h10));
        op("post_rst_ld", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 0, rd, er);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/data_mem_unit.md
DATA_MEM_UNIT -- requirements
Module: data_mem_unit

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 512, meaning number of 32-bit words stored.
REQ-002 SHALL have parameter RD_LATENCY, default 1, meaning cycles from read acceptance to response, legal range 1..4.
REQ-003 SHALL have parameter ADDR_W, default 32, meaning byte-address width.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-006 SHALL have port req_valid, input, 1, request present.
REQ-007 SHALL have port req_ready, output, 1, unit can accept a request.
REQ-008 SHALL have port req_we, input, 1, 1 = store, 0 = load.
REQ-009 SHALL have port req_size, input, 2, access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-010 SHALL have port req_unsigned, input, 1, load zero-extends when 1, sign-extends when 0.
REQ-011 SHALL have port req_addr, input, ADDR_W, byte address.
REQ-012 SHALL have port req_wdata, input, 32, store data, right-aligned (low bits).
REQ-013 SHALL have port rsp_valid, output, 1, response present.
REQ-014 SHALL have port rsp_ready, input, 1, consumer accepts response.
REQ-015 SHALL have port rsp_rdata, output, 32, extended load data; 0 for stores and errors.
REQ-016 SHALL have port rsp_err, output, 1, request was misaligned, out of range or illegal size.
REQ-017 SHALL have port probe_addr, input, $clog2(DEPTH_WORDS), word index for debug observation.
REQ-018 SHALL have port probe_data, output, 32, combinational copy of the word at probe_addr.

Function
REQ-019 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-020 SHALL accept a request when req_valid and req_ready are both 1 on a rising edge, capturing all req_* fields.
REQ-021 SHALL flag an error when: size = 11, half address bit0 = 1, word address bits[1:0] != 0, or word index >= DEPTH_WORDS.
REQ-022 SHALL, on an accepted error request, perform no memory write and go IDLE -> RESP, with rsp_err = 1 and rsp_rdata = 0.
REQ-023 SHALL, on an accepted legal store, write only the addressed byte lanes (little-endian) at the acceptance edge and go IDLE -> RESP.
REQ-024 SHALL, on an accepted legal load, go IDLE -> WAIT, load a counter with RD_LATENCY-1, decrement it each cycle, and enter RESP on the edge where it is 0, so that rsp_valid first rises exactly RD_LATENCY cycles after acceptance.
REQ-025 SHALL extract the addressed byte or half from the word and sign- or zero-extend it to 32 bits per req_unsigned; word loads return the word unchanged.
REQ-026 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready = 1, then return to IDLE on that edge.
REQ-027 SHALL return load data reflecting all stores whose response preceded the load's acceptance.
REQ-028 SHALL NOT accept a new request in the cycle a response is consumed; the next acceptance occurs at the earliest on the following edge.
REQ-029 SHALL drive probe_data combinationally from storage, reflecting a store on the cycle after the store's write edge.

Reset
REQ-030 SHALL, while rst_n = 0 at a rising edge, force the FSM to IDLE, the counter to 0, rsp_valid = 0, rsp_err = 0 and rsp_rdata = 0.
REQ-031 SHALL abandon any in-flight load or unconsumed response on reset, with no response produced afterwards.
REQ-032 SHALL NOT reset memory contents; a store accepted on the same edge as an asserted reset SHALL NOT be performed.

Structure
REQ-033 SHALL take the access-size enum (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state enum from shared package mem_pkg.
REQ-034 SHALL implement load extraction and extension in a combinational sub-module named load_align.

Verification
REQ-035 SHALL cover: store word 0xDEADBEEF at 0x40, load word at 0x40 -> rsp_rdata 0xDEADBEEF, rsp_err 0, RD_LATENCY cycles after acceptance.
REQ-036 SHALL cover: store byte 0x80 at 0x41, then load byte at 0x41 signed -> 0xFFFFFF80, and unsigned -> 0x00000080; word at 0x40 reads 0xDEAD80EF.
REQ-037 SHALL cover: load half at 0x43 -> rsp_err 1, rsp_rdata 0; store word at 0x42 -> rsp_err 1, memory unchanged per probe_data.
REQ-038 SHALL cover: word load at byte address DEPTH_WORDS*4 -> rsp_err 1; req_size 11 -> rsp_err 1.
REQ-039 SHALL cover: rsp_ready held 0 for 5 cycles -> rsp_valid and data stable, req_ready 0 throughout; release -> IDLE next cycle.
REQ-040 SHALL cover: with RD_LATENCY = 3, rst_n driven low in WAIT -> no rsp_valid afterwards, req_ready 1 on the cycle after reset is released.
